regb_fifo_lvl: RTL and testbench

//  Parametrised successor of the register-based FIFO: N x WIDTH entries held in flip-flops, circular read/write pointers.

---
 rtl/regb_fifo_lvl_pkg.sv | 39 +++
 rtl/regb_fifo_lvl_ctrl.sv | 136 +++++++++++++
 rtl/regb_fifo_lvl.sv | 107 ++++++++++
 tb/tb_regb_fifo_lvl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/regb_fifo_lvl_pkg.sv
// ---------------------------------------------------------------------------
// regb_fifo_lvl_pkg
//   Shared definitions for the register-based level FIFO:
//   - default geometry constants
//   - level update operation encoding
//   - clog2 helper used to size level and pointer fields
// ---------------------------------------------------------------------------
package regb_fifo_lvl_pkg;

  localparam int DEF_WIDTH    = 8;
  localparam int DEF_N        = 5;
  localparam int DEF_AE_LEVEL = 1;

  // How the fill level moves in a given cycle.
  typedef enum logic [1:0] {
    LVL_HOLD = 2'b00,
    LVL_INC  = 2'b01,
    LVL_DEC  = 2'b10
  } lvl_op_e;

  // Ceiling log2, at least 1 so that every derived field has a real bit.
  function automatic int clog2(input int value);
    int res;
    int v;
    res = 0;
    v   = value - 1;
    while (v > 0) begin
      res = res + 1;
      v   = v >> 1;
    end
    if (res < 1) begin
      res = 1;
    end else begin
      res = res;
    end
    return res;
  endfunction

endpackage

// File: rtl/regb_fifo_lvl_ctrl.sv
// ---------------------------------------------------------------------------
// regb_fifo_lvl_ctrl
//   Control half of the FIFO: read/write pointers, fill level, accept logic,
//   status flags and sticky error flags. No data path.
//   Ports:
//     clk, res_n          clock, async active-low reset
//     shift_in, shift_out push / pop requests
//     clr_err             synchronous clear of overflow/underflow
//     push_acc, pop_acc   accepted push / pop this cycle
//     wr_ptr, rd_ptr      storage slot to write / head slot
//     level               number of stored entries
//     full, empty, almost_full, almost_empty   flags, registered
//     overflow, underflow sticky rejected-request flags
// ---------------------------------------------------------------------------
module regb_fifo_lvl_ctrl
  import regb_fifo_lvl_pkg::*;
#(
  parameter  int N        = DEF_N,
  parameter  int AF_LEVEL = N - 1,
  parameter  int AE_LEVEL = DEF_AE_LEVEL,
  localparam int LW       = clog2(N + 1),
  localparam int PW       = clog2(N)
) (
  input  logic          clk,
  input  logic          res_n,
  input  logic          shift_in,
  input  logic          shift_out,
  input  logic          clr_err,
  output logic          push_acc,
  output logic          pop_acc,
  output logic [PW-1:0] wr_ptr,
  output logic [PW-1:0] rd_ptr,
  output logic [LW-1:0] level,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          almost_empty,
  output logic          overflow,
  output logic          underflow
);

  localparam logic [LW-1:0] LVL_N    = LW'(N);
  localparam logic [LW-1:0] LVL_AF   = LW'(AF_LEVEL);
  localparam logic [LW-1:0] LVL_AE   = LW'(AE_LEVEL);
  localparam logic [PW-1:0] PTR_LAST = PW'(N - 1);

  lvl_op_e       lvl_op_s;
  logic [LW-1:0] level_nxt_s;
  logic          push_rej_s;
  logic          pop_rej_s;

  // Pointers wrap by compare so N need not be a power of two.
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] ptr);
    logic [PW-1:0] res;
    if (ptr == PTR_LAST) begin
      res = {PW{1'b0}};
    end else begin
      res = ptr + PW'(1);
    end
    return res;
  endfunction

  // A pop frees a slot in the same cycle, so a full FIFO still takes a push.
  assign pop_acc    = shift_out & ~empty;
  assign push_acc   = shift_in & (~full | pop_acc);
  assign push_rej_s = shift_in & ~push_acc;
  assign pop_rej_s  = shift_out & ~pop_acc;

  // Classify the level change for this cycle.
  always_comb begin
    lvl_op_s = LVL_HOLD;
    if (push_acc && !pop_acc) begin
      lvl_op_s = LVL_INC;
    end else if (pop_acc && !push_acc) begin
      lvl_op_s = LVL_DEC;
    end else begin
      lvl_op_s = LVL_HOLD;
    end
  end

  // Next fill level.
  always_comb begin
    level_nxt_s = level;
    case (lvl_op_s)
      LVL_INC: level_nxt_s = level + LW'(1);
      LVL_DEC: level_nxt_s = level - LW'(1);
      default: level_nxt_s = level;
    endcase
  end

  // Pointer, level and flag registers; flags are decoded from the next level
  // so they always match the registered level with no input-to-flag path.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      wr_ptr       <= {PW{1'b0}};
      rd_ptr       <= {PW{1'b0}};
      level        <= {LW{1'b0}};
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      if (push_acc) begin
        wr_ptr <= ptr_next(wr_ptr);
      end
      if (pop_acc) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      level        <= level_nxt_s;
      full         <= (level_nxt_s == LVL_N);
      empty        <= (level_nxt_s == {LW{1'b0}});
      almost_full  <= (level_nxt_s >= LVL_AF);
      almost_empty <= (level_nxt_s <= LVL_AE);
    end
  end

  // Sticky error flags; a new error wins over a same-cycle clear.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push_rej_s) begin
        overflow <= 1'b1;
      end else if (clr_err) begin
        overflow <= 1'b0;
      end
      if (pop_rej_s) begin
        underflow <= 1'b1;
      end else if (clr_err) begin
        underflow <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/regb_fifo_lvl.sv
// ---------------------------------------------------------------------------
// regb_fifo_lvl
//   Register-based FIFO of N x WIDTH flip-flop entries with fill level,
//   almost-full/almost-empty flags, sticky overflow/underflow and a
//   selectable output mode.
//   Ports:
//     clk, res_n        clock, async active-low reset
//     shift_in, wdata   push request and write data
//     shift_out         pop request
//     rdata, rvalid     read data / valid (FWFT=1: head shown while non-empty;
//                       FWFT=0: registered, valid the cycle after a pop)
//     full, empty, almost_full, almost_empty, level   status
//     overflow, underflow   sticky errors, cleared by clr_err
// ---------------------------------------------------------------------------
module regb_fifo_lvl
  import regb_fifo_lvl_pkg::*;
#(
  parameter  int WIDTH    = DEF_WIDTH,
  parameter  int N        = DEF_N,
  parameter  int FWFT     = 1,
  parameter  int AF_LEVEL = N - 1,
  parameter  int AE_LEVEL = DEF_AE_LEVEL,
  localparam int LW       = clog2(N + 1)
) (
  input  logic             clk,
  input  logic             res_n,
  input  logic             shift_in,
  input  logic [WIDTH-1:0] wdata,
  input  logic             shift_out,
  output logic [WIDTH-1:0] rdata,
  output logic             rvalid,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [LW-1:0]    level,
  output logic             overflow,
  output logic             underflow,
  input  logic             clr_err
);

  localparam int PW = clog2(N);

  logic             push_acc_s;
  logic             pop_acc_s;
  logic [PW-1:0]    wr_ptr_s;
  logic [PW-1:0]    rd_ptr_s;
  logic [WIDTH-1:0] mem_r [N];

  regb_fifo_lvl_ctrl #(
    .N        (N),
    .AF_LEVEL (AF_LEVEL),
    .AE_LEVEL (AE_LEVEL)
  ) u_ctrl (
    .clk          (clk),
    .res_n        (res_n),
    .shift_in     (shift_in),
    .shift_out    (shift_out),
    .clr_err      (clr_err),
    .push_acc     (push_acc_s),
    .pop_acc      (pop_acc_s),
    .wr_ptr       (wr_ptr_s),
    .rd_ptr       (rd_ptr_s),
    .level        (level),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  // Storage write; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (push_acc_s) begin
      mem_r[wr_ptr_s] <= wdata;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word shown directly; gated to zero while empty.
      assign rdata  = empty ? {WIDTH{1'b0}} : mem_r[rd_ptr_s];
      assign rvalid = ~empty;
    end else begin : g_reg
      logic [WIDTH-1:0] rdata_r;
      logic             rvalid_r;

      // Registered read port: capture the head on an accepted pop.
      always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
          rdata_r  <= {WIDTH{1'b0}};
          rvalid_r <= 1'b0;
        end else if (pop_acc_s) begin
          rdata_r  <= mem_r[rd_ptr_s];
          rvalid_r <= 1'b1;
        end else begin
          rvalid_r <= 1'b0;
        end
      end

      assign rdata  = rdata_r;
      assign rvalid = rvalid_r;
    end
  endgenerate

endmodule

// File: tb/tb_regb_fifo_lvl.sv
// ---------------------------------------------------------------------------
// tb_regb_fifo_lvl
//   Directed bench: one FWFT=1 instance (a_*) and one FWFT=0 instance (b_*).
// ---------------------------------------------------------------------------
module tb_regb_fifo_lvl;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // FWFT instance signals
  logic       a_res_n, a_si, a_so, a_clr;
  logic [7:0] a_wd, a_rd;
  logic       a_rv, a_full, a_empty, a_af, a_ae, a_ovf, a_unf;
  logic [2:0] a_lvl;

  // Registered-output instance signals
  logic       b_res_n, b_si, b_so, b_clr;
  logic [7:0] b_wd, b_rd;
  logic       b_rv, b_full, b_empty, b_af, b_ae, b_ovf, b_unf;
  logic [2:0] b_lvl;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] exp_head [7];

  regb_fifo_lvl #(.WIDTH(8), .N(5), .FWFT(1)) u_a (
    .clk(clk), .res_n(a_res_n), .shift_in(a_si), .wdata(a_wd), .shift_out(a_so),
    .rdata(a_rd), .rvalid(a_rv), .full(a_full), .empty(a_empty),
    .almost_full(a_af), .almost_empty(a_ae), .level(a_lvl),
    .overflow(a_ovf), .underflow(a_unf), .clr_err(a_clr)
  );

  regb_fifo_lvl #(.WIDTH(8), .N(5), .FWFT(0)) u_b (
    .clk(clk), .res_n(b_res_n), .shift_in(b_si), .wdata(b_wd), .shift_out(b_so),
    .rdata(b_rd), .rvalid(b_rv), .full(b_full), .empty(b_empty),
    .almost_full(b_af), .almost_empty(b_ae), .level(b_lvl),
    .overflow(b_ovf), .underflow(b_unf), .clr_err(b_clr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle on instance A; returns 1 time unit after the edge.
  task automatic step_a(input logic si, input logic so, input logic [7:0] wd, input logic clr);
    a_si = si; a_so = so; a_wd = wd; a_clr = clr;
    @(posedge clk); #1;
    a_si = 1'b0; a_so = 1'b0; a_clr = 1'b0;
  endtask

  task automatic step_b(input logic si, input logic so, input logic [7:0] wd);
    b_si = si; b_so = so; b_wd = wd;
    @(posedge clk); #1;
    b_si = 1'b0; b_so = 1'b0;
  endtask

  initial begin
    exp_head[0] = 8'h22; exp_head[1] = 8'h33; exp_head[2] = 8'h44; exp_head[3] = 8'h55;
    exp_head[4] = 8'h66; exp_head[5] = 8'h77; exp_head[6] = 8'h88;
    a_res_n = 1'b0; a_si = 1'b0; a_so = 1'b0; a_clr = 1'b0; a_wd = 8'h00;
    b_res_n = 1'b0; b_si = 1'b0; b_so = 1'b0; b_clr = 1'b0; b_wd = 8'h00;

    // Reset state
    #100;
    chk("rst_empty", a_empty, 1);
    chk("rst_full", a_full, 0);
    chk("rst_level", a_lvl, 0);
    chk("rst_ae", a_ae, 1);
    chk("rst_af", a_af, 0);
    chk("rst_ovf", a_ovf, 0);
    chk("rst_unf", a_unf, 0);
    chk("rst_rvalid", a_rv, 0);
    chk("rst_rdata", a_rd, 0);
    chk("rst_b_rvalid", b_rv, 0);
    chk("rst_b_rdata", b_rd, 0);
    a_res_n = 1'b1; b_res_n = 1'b1;
    @(posedge clk); #1;

    // Fill with 0x11..0x55
    for (int i = 1; i <= 5; i++) begin
      step_a(1'b1, 1'b0, 8'(i * 17), 1'b0);
      chk("fill_level", a_lvl, i);
      chk("fill_full", a_full, (i == 5) ? 1 : 0);
      chk("fill_af", a_af, (i >= 4) ? 1 : 0);
      chk("fill_ae", a_ae, (i <= 1) ? 1 : 0);
      chk("fill_head", a_rd, 8'h11);
    end
    step_a(1'b1, 1'b0, 8'h77, 1'b0);
    chk("ovf_level", a_lvl, 5);
    chk("ovf_flag", a_ovf, 1);
    chk("ovf_head", a_rd, 8'h11);

    // Drain in order
    for (int i = 1; i <= 5; i++) begin
      chk("drain_rdata", a_rd, 8'(i * 17));
      chk("drain_rvalid", a_rv, 1);
      step_a(1'b0, 1'b1, 8'h00, 1'b0);
      chk("drain_level", a_lvl, 5 - i);
    end
    chk("drained_empty", a_empty, 1);
    chk("drained_rdata", a_rd, 0);
    chk("drained_rvalid", a_rv, 0);
    step_a(1'b0, 1'b1, 8'h00, 1'b0);
    chk("unf_flag", a_unf, 1);
    chk("unf_level", a_lvl, 0);
    chk("unf_ovf_sticky", a_ovf, 1);
    step_a(1'b0, 1'b0, 8'h00, 1'b1);
    chk("clr_ovf", a_ovf, 0);
    chk("clr_unf", a_unf, 0);

    // Full + simultaneous push/pop across pointer wrap
    for (int i = 1; i <= 5; i++) begin
      step_a(1'b1, 1'b0, 8'(i * 17), 1'b0);
    end
    chk("refill_full", a_full, 1);
    for (int k = 0; k < 7; k++) begin
      step_a(1'b1, 1'b1, 8'(8'h66 + k * 17), 1'b0);
      chk("pp_head", a_rd, exp_head[k]);
      chk("pp_level", a_lvl, 5);
      chk("pp_ovf", a_ovf, 0);
      chk("pp_full", a_full, 1);
    end
    for (int i = 0; i < 5; i++) begin
      chk("wrap_drain", a_rd, 8'(8'h88 + i * 17));
      step_a(1'b0, 1'b1, 8'h00, 1'b0);
    end
    chk("wrap_empty", a_empty, 1);
    chk("wrap_unf", a_unf, 0);

    // Empty + simultaneous push/pop
    step_a(1'b1, 1'b1, 8'hA5, 1'b0);
    chk("ep_level", a_lvl, 1);
    chk("ep_unf", a_unf, 1);
    chk("ep_rdata", a_rd, 8'hA5);
    chk("ep_rvalid", a_rv, 1);

    // Set wins over a same-cycle clear
    step_a(1'b0, 1'b1, 8'h00, 1'b0);
    step_a(1'b0, 1'b0, 8'h00, 1'b1);
    chk("clr2_unf", a_unf, 0);
    step_a(1'b0, 1'b1, 8'h00, 1'b1);
    chk("setwins_unf", a_unf, 1);

    // Registered-output instance
    step_b(1'b1, 1'b0, 8'h3C);
    chk("b_push_level", b_lvl, 1);
    chk("b_push_rvalid", b_rv, 0);
    step_b(1'b0, 1'b1, 8'h00);
    chk("b_pop_rvalid", b_rv, 1);
    chk("b_pop_rdata", b_rd, 8'h3C);
    chk("b_pop_level", b_lvl, 0);
    step_b(1'b0, 1'b0, 8'h00);
    chk("b_idle_rvalid", b_rv, 0);
    chk("b_idle_rdata", b_rd, 8'h3C);
    step_b(1'b0, 1'b1, 8'h00);
    chk("b_emptypop_rvalid", b_rv, 0);
    chk("b_emptypop_unf", b_unf, 1);
    step_b(1'b1, 1'b0, 8'h01);
    step_b(1'b1, 1'b0, 8'h02);
    step_b(1'b1, 1'b0, 8'h03);
    chk("b_mid_level", b_lvl, 3);
    #2 b_res_n = 1'b0;
    #1;
    chk("b_arst_level", b_lvl, 0);
    chk("b_arst_empty", b_empty, 1);
    chk("b_arst_rdata", b_rd, 0);
    chk("b_arst_unf", b_unf, 0);
    #2 b_res_n = 1'b1;
    step_b(1'b0, 1'b1, 8'h00);
    chk("b_post_level", b_lvl, 0);
    chk("b_post_rvalid", b_rv, 0);
    step_b(1'b1, 1'b0, 8'h5A);
    step_b(1'b0, 1'b1, 8'h00);
    chk("b_post_rdata", b_rd, 8'h5A);
    chk("b_post_rv", b_rv, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
